huff_bitwin_p: RTL
==================

Name: huff_bitwin_p

Overview:
- Parametrised bit-window reader for the JPEG Huffman decode path. Sits between the byte-stream file reader and the Huffman symbol decoder.
- Accepts file bytes and removes JPEG byte stuffing (0xFF 0x00 becomes 0xFF).
- Serves "peek N bits" requests and "advance N bits" commands on independent streams.
- Successor to the fixed 16-bit token reader:
  - generalised token and buffer widths;
  - adds marker detection with 1-padding;
  - adds a marker output stream and a stuffing-bypass mode.

Parameters:
- TOKEN_W, 16, width of parsedToken_d; the maximum peek size.
- CNT_W, 8, width of reqSize_d and advance_d.
- BUF_W, 32, bit-buffer depth; must be ≥ TOKEN_W+8.
- STUFF_EN, 1, 1 = remove 0x00 after 0xFF and detect markers; 0 = raw byte stream.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- filebyte_d  in  8  input byte.
- filebyte_e  in  1  end-of-stream token flag.
- filebyte_v  in  1  valid.
- filebyte_b  out  1  back-pressure to the byte producer.
- reqSize_d  in  CNT_W  number of bits to peek (1..TOKEN_W).
- reqSize_e  in  1  end-of-stream.
- reqSize_v  in  1  valid.
- reqSize_b  out  1  back-pressure.
- advance_d  in  CNT_W  number of bits to consume (0..TOKEN_W).
- advance_e, advance_v  in  1 each.
- advance_b  out  1  back-pressure.
- parsedToken_d  out  TOKEN_W  peeked bits, right-aligned, zero-extended.
- parsedToken_e, parsedToken_v  out  1 each.
- parsedToken_b  in  1  downstream back-pressure.
- marker_d  out  8  detected marker code (second byte after 0xFF).
- marker_v  out  1  marker valid.
- marker_b  in  1  back-pressure.

Behaviour:
- Handshake on every stream: transfer when _v=1 and _b=0. Outputs hold _d/_e/_v stable while _b=1.
- Reset (reset=0, asynchronous):
  - bit buffer and bit count cleared;
  - state=FILL;
  - parsedToken_v=0, parsedToken_e=0, marker_v=0;
  - filebyte_b=0, reqSize_b=1, advance_b=1.
- Bit buffer:
  - MSB-first; count = valid bits.
  - A byte is appended only when count ≤ BUF_W-8; otherwise filebyte_b=1.
- State machine, states FILL, WAIT_ZERO, MARKER, EOS:
  - FILL, byte≠0xFF (or STUFF_EN=0): append.
  - FILL, byte=0xFF: append, go to WAIT_ZERO.
  - WAIT_ZERO, byte=0x00: discard the 0x00, go to FILL.
  - WAIT_ZERO, byte≠0x00:
    - remove the already-appended 0xFF (count-=8);
    - latch the code to marker_d and raise marker_v;
    - go to MARKER.
  - MARKER: filebyte_b=1; buffer is treated as infinitely 1-padded. Stays in MARKER until reset or end of stream (filebyte_e transfer is not accepted while in MARKER; filebyte_b=1 covers it).
  - filebyte_e transfer in FILL or WAIT_ZERO: go to EOS. Buffer is 1-padded; a pending 0xFF is kept as data.
- Request, reqSize_b=0 when all hold:
  - parsedToken_v=0 or the output is being taken this cycle;
  - count ≥ reqSize_d, or state is MARKER or EOS.
- Request result:
  - parsedToken_d = top reqSize_d bits, 1-padded beyond count, registered. Latency 1 cycle from accept to parsedToken_v.
  - reqSize_d > TOKEN_W is clamped to TOKEN_W.
  - reqSize_d=0 returns 0.
- Advance:
  - advance_b=0 when count ≥ advance_d or state is MARKER/EOS.
  - Shifts out advance_d bits; count saturates at 0.
- Simultaneous valid advance and request in the same cycle:
  - advance is accepted first;
  - request is held (reqSize_b=1) that cycle;
  - at most one command accepted per cycle.
- End-of-stream propagation:
  - reqSize_e transfer emits one parsedToken with _e=1, data 0, then stops accepting (reqSize_b=1) until reset.
  - advance_e is accepted and ignored.
- Simultaneous byte append and advance in one cycle: count = count+8-advance_d. Both are permitted when the sum fits in BUF_W.

Decomposition:
- Shared package constants: state encodings (FILL, WAIT_ZERO, MARKER, EOS), JPEG_FF=8'hFF, STUFF_ZERO=8'h00.
- Function to clamp the request size.
- One natural sub-module: huff_bitbuf_shift, holding the buffer register, count, append, shift and 1-padded extract. Control FSM and handshakes stay in the top module.

Test Plan:
- Bytes 0xA5,0x3C; req 4 → token 0xA. Advance 4, req 8 → token 0x53. Advance 8, req 4 → token 0xC.
- Bytes 0xFF,0x00,0x12; req 16 → 0xFF12; the 0x00 never appears.
- Bytes 0x81,0xFF,0xD9:
  - marker_v=1 with marker_d=0xD9;
  - req 12 → 0x81F (1-padded);
  - filebyte_b held at 1.
- parsedToken_b=1 for 5 cycles after a token issues → parsedToken_d/_v stable; reqSize_b=1 throughout. Release → next request accepted the following cycle.
- Mid-stream byte 0x40 then filebyte_e; req 10 → 0x103 (padded). reqSize_e → one token with _e=1.
- Assert reset low mid-request with parsedToken_v=1 → parsedToken_v=0 immediately, count 0, state FILL, no token emitted after release.

Source files
------------

// File: rtl/huff_bitwin_p_pkg.sv
// huff_bitwin_p_pkg: shared states, JPEG byte codes and request clamp for the bit-window reader.
package huff_bitwin_p_pkg;
   typedef enum logic [1:0] {FILL, WAIT_ZERO, MARKER, EOS} state_t;
   localparam logic [7:0] JPEG_FF    = 8'hFF;
   localparam logic [7:0] STUFF_ZERO = 8'h00;
   function automatic int unsigned clamp_req(input int unsigned req, input int unsigned max_n);
      return req > max_n ? max_n : req;
   endfunction
endpackage

// File: rtl/huff_bitbuf_shift.sv
// huff_bitbuf_shift: MSB-first bit buffer with byte append, tail-byte drop, left shift and 1-padded peek.
module huff_bitbuf_shift #(
   parameter int BUF_W   = 32,
   parameter int TOKEN_W = 16,
   parameter int CNT_W   = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         app_i,
   input  logic                         drop_i,
   input  logic [7:0]                   byte_i,
   input  logic [CNT_W-1:0]             adv_i,
   input  logic [CNT_W-1:0]             peek_n_i,
   output logic [TOKEN_W-1:0]           peek_o,
   output logic [$clog2(BUF_W+1)-1:0]   count_o
);
   localparam int N_W = $clog2(BUF_W + 1);
   localparam logic [BUF_W-1:0] TOP_BYTE = {8'hFF, {(BUF_W-8){1'b0}}};
   logic [BUF_W-1:0] bits_q, bits_d, kept, appd;
   logic [N_W-1:0] cnt_q, cnt_d, base;
   logic [TOKEN_W-1:0] top;
   int unsigned tot;
   // bits at or beyond the count are kept zero, so appending is a plain OR
   always_comb begin
      base = !drop_i ? cnt_q : cnt_q >= N_W'(8) ? cnt_q - N_W'(8) : '0;
      kept = drop_i ? bits_q & ~(TOP_BYTE >> base) : bits_q;
      appd = app_i ? kept | ({byte_i, {(BUF_W-8){1'b0}}} >> base) : kept;
      tot = 32'(base) + (app_i ? 32'd8 : 32'd0);
      bits_d = appd << adv_i;
      cnt_d = tot > 32'(adv_i) ? N_W'(tot - 32'(adv_i)) : '0;
      top = TOKEN_W'((bits_q | ({BUF_W{1'b1}} >> cnt_q)) >> (BUF_W - TOKEN_W));
      peek_o = top >> (TOKEN_W - int'(peek_n_i));
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bits_q <= '0;
         cnt_q  <= '0;
      end else begin
         bits_q <= bits_d;
         cnt_q  <= cnt_d;
      end
   end
   assign count_o = cnt_q;
endmodule

// File: rtl/huff_bitwin_p.sv
// huff_bitwin_p: JPEG bit-window reader with byte unstuffing, marker detection and 1-padded peeks.
module huff_bitwin_p
   import huff_bitwin_p_pkg::*;
#(
   parameter int TOKEN_W  = 16,
   parameter int CNT_W    = 8,
   parameter int BUF_W    = 32,
   parameter bit STUFF_EN = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [7:0]         filebyte_d,
   input  logic               filebyte_e,
   input  logic               filebyte_v,
   output logic               filebyte_b,
   input  logic [CNT_W-1:0]   reqSize_d,
   input  logic               reqSize_e,
   input  logic               reqSize_v,
   output logic               reqSize_b,
   input  logic [CNT_W-1:0]   advance_d,
   input  logic               advance_e,
   input  logic               advance_v,
   output logic               advance_b,
   output logic [TOKEN_W-1:0] parsedToken_d,
   output logic               parsedToken_e,
   output logic               parsedToken_v,
   input  logic               parsedToken_b,
   output logic [7:0]         marker_d,
   output logic               marker_v,
   input  logic               marker_b
);
   localparam int N_W = $clog2(BUF_W + 1);
   state_t state_q;
   logic run_q, stop_q, tok_v_q, tok_e_q, mk_v_q;
   logic [TOKEN_W-1:0] tok_q, peek;
   logic [7:0] mk_q;
   logic [N_W-1:0] count;
   logic [CNT_W-1:0] req_n, adv_n;
   logic padded, fb_go, adv_go, req_go, app, drop;
   assign padded     = state_q == MARKER || state_q == EOS;
   assign filebyte_b = padded || 32'(count) > 32'(BUF_W - 8);
   assign fb_go      = filebyte_v && !filebyte_b;
   assign app        = fb_go && !filebyte_e && state_q == FILL;
   assign drop       = fb_go && !filebyte_e && state_q == WAIT_ZERO && filebyte_d != STUFF_ZERO;
   assign advance_b  = !run_q || !(padded || advance_e || 32'(count) >= 32'(advance_d));
   assign adv_go     = advance_v && !advance_b;
   assign adv_n      = adv_go && !advance_e ? advance_d : '0;
   assign req_n      = CNT_W'(clamp_req(32'(reqSize_d), 32'(TOKEN_W)));
   // an accepted advance always wins the cycle over a pending request
   assign reqSize_b  = !run_q || stop_q || adv_go || (tok_v_q && parsedToken_b) ||
                       !(padded || reqSize_e || 32'(count) >= 32'(req_n));
   assign req_go     = reqSize_v && !reqSize_b;
   huff_bitbuf_shift #(.BUF_W(BUF_W), .TOKEN_W(TOKEN_W), .CNT_W(CNT_W)) u_buf (
      .clock    (clock),
      .reset    (reset),
      .app_i    (app),
      .drop_i   (drop),
      .byte_i   (filebyte_d),
      .adv_i    (adv_n),
      .peek_n_i (req_n),
      .peek_o   (peek),
      .count_o  (count)
   );
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
         run_q   <= 1'b0;
         stop_q  <= 1'b0;
         tok_v_q <= 1'b0;
         tok_e_q <= 1'b0;
         tok_q   <= '0;
         mk_v_q  <= 1'b0;
         mk_q    <= '0;
      end else begin
         run_q <= 1'b1;
         if (fb_go) begin
            if (filebyte_e) state_q <= EOS;
            else if (state_q == FILL && STUFF_EN && filebyte_d == JPEG_FF) state_q <= WAIT_ZERO;
            else if (state_q == WAIT_ZERO) state_q <= drop ? MARKER : FILL;
         end
         if (drop) begin
            mk_q   <= filebyte_d;
            mk_v_q <= 1'b1;
         end else if (!marker_b) mk_v_q <= 1'b0;
         if (req_go) begin
            tok_q   <= reqSize_e ? '0 : peek;
            tok_e_q <= reqSize_e;
            tok_v_q <= 1'b1;
            stop_q  <= reqSize_e;
         end else if (!parsedToken_b) tok_v_q <= 1'b0;
      end
   end
   assign parsedToken_d = tok_q;
   assign parsedToken_e = tok_e_q;
   assign parsedToken_v = tok_v_q;
   assign marker_d      = mk_q;
   assign marker_v      = mk_v_q;
endmodule
